debounce_one_pulse: RTL and testbench
=====================================

// Module: debounce_one_pulse
// PURPOSE
//  Converts a slow, bouncy, asynchronous level (push-button, switch, stretched strobe) into clean
//  single-cycle strobes in the clk domain: inverse of pulse stretching. Sits between board inputs
//  and control FSMs; provides a debounced level, press/release strobes and optional auto-repeat.
// PARAMETERS
//  SYNC_STAGES    2         synchronizer depth, >=2
//  DB_CYCLES      65536     consecutive equal synced samples required to accept a level change, >=2
//  REPEAT_EN      0         1: generate auto-repeat strobes while held
//  HOLD_CYCLES    16777216  cycles in HELD before first repeat strobe, >=1
//  REPEAT_CYCLES  4194304   cycles between subsequent repeat strobes, >=1
// PORTS
//  clk            in   1  clock
//  rst            in   1  reset, asynchronous, active-high
//  raw_in         in   1  asynchronous raw level
//  level_out      out  1  debounced level
//  press_pulse    out  1  one-cycle strobe on accepted 0->1
//  release_pulse  out  1  one-cycle strobe on accepted 1->0
//  repeat_pulse   out  1  one-cycle auto-repeat strobe (0 when REPEAT_EN=0)
// BEHAVIOUR
//  - Reset: sync chain, counters, all outputs = 0; FSM = IDLE. Reset is async; outputs are registered.
//  - raw_in passes through SYNC_STAGES flops -> s. Only s is used downstream.
//  - db_cnt width $clog2(DB_CYCLES)+1; hold_cnt width covers max(HOLD_CYCLES, REPEAT_CYCLES).
//  - FSM states: IDLE, ARM_HI, HELD, ARM_LO.
//    IDLE:   s=1 -> ARM_HI, db_cnt=1.
//    ARM_HI: s=0 -> IDLE, db_cnt=0, no strobe (glitch rejected).
//            s=1 and db_cnt==DB_CYCLES-1 -> HELD; press_pulse=1, level_out=1 that cycle; hold_cnt=0.
//            else db_cnt+1.
//    HELD:   s=0 -> ARM_LO, db_cnt=1; hold_cnt frozen.
//            s=1 -> hold_cnt+1; REPEAT_EN and hold_cnt+1==HOLD_CYCLES -> repeat_pulse, and
//            thereafter every REPEAT_CYCLES (hold_cnt reloads to HOLD_CYCLES-REPEAT_CYCLES on strobe).
//    ARM_LO: s=1 -> HELD, db_cnt=0, no strobe, level_out stays 1, hold_cnt resumes.
//            s=0 and db_cnt==DB_CYCLES-1 -> IDLE; release_pulse=1, level_out=0 that cycle.
//            else db_cnt+1.
//  - Latency: raw_in rising before edge 0 and held -> press_pulse high in cycle after edge
//    SYNC_STAGES+DB_CYCLES-1; symmetric for release.
//  - Strobes are exactly one cycle and mutually exclusive; no repeat_pulse in ARM_HI/ARM_LO/IDLE.
//  - Bounce in ARM_LO never produces a second press_pulse; bounce in ARM_HI never a release_pulse.
//  - Reset mid-operation: outputs drop immediately; raw_in still high after release of rst is a
//    new press (full latency, press_pulse emitted).
//  - hold_cnt saturates rather than wraps when REPEAT_EN=0.
// STRUCTURE
//  - Package pulse_pkg: state enum (IDLE, ARM_HI, HELD, ARM_LO), counter-width helper function.
//  - Sub-module sync_chain #(STAGES) (clk, rst, d, q): reset-to-0 flop chain, reusable elsewhere.
//  - Top: one FSM always block + counter logic + registered outputs.
// TESTING  (SYNC_STAGES=2, DB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=5, REPEAT_EN=1 unless noted)
//  - Clean press: raw_in 0->1 before edge 0, held 8 cycles -> press_pulse 1 cycle after edge 5,
//    level_out 1 from same cycle, no other strobe.
//  - Glitch: raw_in high 3 cycles then low -> no strobes, level_out stays 0.
//  - Release bounce: from HELD, raw_in 0 for 2, 1 for 1, 0 for 10 -> exactly one release_pulse,
//    level_out falls once, no press_pulse.
//  - Auto-repeat: press (strobe at cycle t) and hold 30 cycles -> repeat_pulse at t+10, t+15,
//    t+20, t+25, t+30; none after release.
//  - Reset mid-hold: rst pulse while HELD with raw_in high -> all outputs 0 asynchronously;
//    after rst low, press_pulse again 1 cycle after edge 5 (relative to first edge post-reset).
//  - REPEAT_EN=0: hold 100 cycles -> repeat_pulse never asserts; press/release behave as above.

Source files
------------

// File: rtl/pulse_pkg.sv
// -----------------------------------------------------------------------------
// pulse_pkg
//   Shared types and helpers for the debounce / one-pulse block.
//   - state_t   : debounce FSM states
//   - max_int   : larger of two integers (elaboration-time sizing)
//   - cnt_width : number of bits needed to hold values 0..max_val
// -----------------------------------------------------------------------------
package pulse_pkg;

  // IDLE   : settled low
  // ARM_HI : low->high seen, counting stable-high samples
  // HELD   : settled high
  // ARM_LO : high->low seen, counting stable-low samples
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM_HI = 2'd1,
    HELD   = 2'd2,
    ARM_LO = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    int r;
    if (a >= b) begin
      r = a;
    end else begin
      r = b;
    end
    return r;
  endfunction

  // Bits required so that max_val itself is representable; never below 1.
  function automatic int cnt_width(input int max_val);
    int r;
    if (max_val <= 1) begin
      r = 1;
    end else begin
      r = $clog2(max_val + 1);
    end
    return r;
  endfunction

endpackage : pulse_pkg

// File: rtl/sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
//   Plain flop-chain synchronizer bringing an asynchronous level into the clk
//   domain. All stages reset to 0.
// Ports
//   clk : clock
//   rst : asynchronous active-high reset
//   d   : asynchronous input level
//   q   : synchronized level (STAGES flops after d)
// -----------------------------------------------------------------------------
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  // Next chain value: shift d in at bit 0, oldest sample leaves at the top.
  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  // Synchronizer flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain_q <= {STAGES{1'b0}};
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule : sync_chain

// File: rtl/debounce_one_pulse.sv
// -----------------------------------------------------------------------------
// debounce_one_pulse
//   Turns a slow, bouncy, asynchronous level (button, switch, stretched strobe)
//   into a debounced level plus single-cycle press / release strobes, with
//   optional auto-repeat strobes while the input is held.
//
// Parameters
//   SYNC_STAGES   synchronizer depth (>=2)
//   DB_CYCLES     consecutive equal synced samples needed to accept a change (>=2)
//   REPEAT_EN     1: emit repeat_pulse while held
//   HOLD_CYCLES   cycles in HELD before the first repeat strobe (>=1)
//   REPEAT_CYCLES cycles between subsequent repeat strobes (>=1)
//
// Ports
//   clk           clock
//   rst           asynchronous active-high reset
//   raw_in        asynchronous raw level
//   level_out     debounced level (registered)
//   press_pulse   one-cycle strobe on accepted 0->1 (registered)
//   release_pulse one-cycle strobe on accepted 1->0 (registered)
//   repeat_pulse  one-cycle auto-repeat strobe, 0 when REPEAT_EN=0 (registered)
// -----------------------------------------------------------------------------
module debounce_one_pulse
  import pulse_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 65536,
  parameter int REPEAT_EN     = 0,
  parameter int HOLD_CYCLES   = 16777216,
  parameter int REPEAT_CYCLES = 4194304
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level_out,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  // ---------------------------------------------------------------------------
  // Sizing
  // ---------------------------------------------------------------------------
  localparam int DB_W     = $clog2(DB_CYCLES) + 1;
  localparam int HOLD_MAX = max_int(HOLD_CYCLES, REPEAT_CYCLES);
  localparam int HOLD_W   = cnt_width(HOLD_MAX);

  localparam logic [DB_W-1:0] DB_ZERO = {DB_W{1'b0}};
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(32'd1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // hold_inc is one bit wider than hold_cnt so the compare never sees a wrap.
  localparam logic [HOLD_W:0]   HOLD_TGT  = (HOLD_W + 1)'(HOLD_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_SAT  = {HOLD_W{1'b1}};
  // Reloading to HOLD-REPEAT makes the next strobe land REPEAT cycles later.
  // If REPEAT exceeds HOLD the reload clamps at 0, so the interval becomes HOLD.
  localparam logic [HOLD_W-1:0] HOLD_RELOAD =
    HOLD_W'((HOLD_CYCLES >= REPEAT_CYCLES) ? (HOLD_CYCLES - REPEAT_CYCLES) : 0);
  localparam logic REP_ON = (REPEAT_EN != 0);

  // ---------------------------------------------------------------------------
  // Synchronizer: only s is used by the FSM, raw_in never reaches it directly.
  // ---------------------------------------------------------------------------
  logic s;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw_in),
    .q   (s)
  );

  // ---------------------------------------------------------------------------
  // State, counters and registered outputs
  // ---------------------------------------------------------------------------
  state_t            state_q,    state_d;
  logic [DB_W-1:0]   db_cnt_q,   db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              level_q,    level_d;
  logic              press_q,    press_d;
  logic              release_q,  release_d;
  logic              repeat_q,   repeat_d;

  logic [HOLD_W:0]   hold_inc;
  logic [DB_W-1:0]   db_inc;

  // Incremented counter values shared by several FSM branches.
  always_comb begin
    hold_inc = {1'b0, hold_cnt_q} + {{HOLD_W{1'b0}}, 1'b1};
    db_inc   = db_cnt_q + DB_ONE;
  end

  // Next-state, counter and output decode for the debounce FSM.
  // Strobes default low so each one lasts exactly the cycle it is decoded in.
  always_comb begin
    state_d    = state_q;
    db_cnt_d   = db_cnt_q;
    hold_cnt_d = hold_cnt_q;
    level_d    = level_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    repeat_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (s) begin
          state_d  = ARM_HI;
          db_cnt_d = DB_ONE;
        end else begin
          db_cnt_d = DB_ZERO;
        end
      end

      ARM_HI: begin
        if (!s) begin
          // Not stable long enough: drop back silently.
          state_d  = IDLE;
          db_cnt_d = DB_ZERO;
        end else if (db_cnt_q == DB_LAST) begin
          state_d    = HELD;
          db_cnt_d   = DB_ZERO;
          hold_cnt_d = HOLD_ZERO;
          level_d    = 1'b1;
          press_d    = 1'b1;
        end else begin
          db_cnt_d = db_inc;
        end
      end

      HELD: begin
        if (!s) begin
          // hold_cnt is frozen so a rejected release resumes the repeat timing.
          state_d  = ARM_LO;
          db_cnt_d = DB_ONE;
        end else if (REP_ON && (hold_inc == HOLD_TGT)) begin
          repeat_d   = 1'b1;
          hold_cnt_d = HOLD_RELOAD;
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_inc[HOLD_W-1:0];
        end else begin
          // Held far longer than any timing of interest: saturate, never wrap.
          hold_cnt_d = hold_cnt_q;
        end
      end

      ARM_LO: begin
        if (s) begin
          // Bounce during release: back to HELD, level stays high, no strobe.
          state_d  = HELD;
          db_cnt_d = DB_ZERO;
        end else if (db_cnt_q == DB_LAST) begin
          state_d   = IDLE;
          db_cnt_d  = DB_ZERO;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          db_cnt_d = db_inc;
        end
      end

      default: begin
        state_d    = IDLE;
        db_cnt_d   = DB_ZERO;
        hold_cnt_d = HOLD_ZERO;
        level_d    = 1'b0;
      end
    endcase
  end

  // FSM state, counters and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      db_cnt_q   <= DB_ZERO;
      hold_cnt_q <= HOLD_ZERO;
      level_q    <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      db_cnt_q   <= db_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      level_q    <= level_d;
      press_q    <= press_d;
      release_q  <= release_d;
      repeat_q   <= repeat_d;
    end
  end

  assign level_out     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;

endmodule : debounce_one_pulse

// File: tb/tb_debounce_one_pulse.sv
// -----------------------------------------------------------------------------
// tb_debounce_one_pulse
//   Two instances share clk/rst/raw_in: dut_a with auto-repeat enabled and
//   dut_b with auto-repeat disabled. Each test pushes the strobes it expects
//   (cycle + kind) into a scoreboard queue when it drives raw_in; a monitor
//   pops and compares them against both instances every falling edge. The
//   expected debounced level follows the press/release entries popped.
// -----------------------------------------------------------------------------
module tb_debounce_one_pulse;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 5;
  // Input change at the falling edge of cycle c -> strobe visible at cycle c+LAT.
  localparam int LAT  = SYNC + DB;

  localparam logic [1:0] K_PRESS   = 2'd0;
  localparam logic [1:0] K_RELEASE = 2'd1;
  localparam logic [1:0] K_REPEAT  = 2'd2;

  typedef struct {
    int         cyc;
    logic [1:0] kind;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic raw_in = 1'b0;

  logic a_level, a_press, a_release, a_repeat;
  logic b_level, b_press, b_release, b_repeat;

  ev_t  sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic exp_level = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  debounce_one_pulse #(
    .SYNC_STAGES   (SYNC),
    .DB_CYCLES     (DB),
    .REPEAT_EN     (1),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP)
  ) dut_a (
    .clk           (clk),
    .rst           (rst),
    .raw_in        (raw_in),
    .level_out     (a_level),
    .press_pulse   (a_press),
    .release_pulse (a_release),
    .repeat_pulse  (a_repeat)
  );

  debounce_one_pulse #(
    .SYNC_STAGES   (SYNC),
    .DB_CYCLES     (DB),
    .REPEAT_EN     (0),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP)
  ) dut_b (
    .clk           (clk),
    .rst           (rst),
    .raw_in        (raw_in),
    .level_out     (b_level),
    .press_pulse   (b_press),
    .release_pulse (b_release),
    .repeat_pulse  (b_repeat)
  );

  task automatic push_ev(input int c, input logic [1:0] k);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    sb.push_back(e);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard monitor: runs forked from the main initial block.
  task automatic scoreboard_monitor();
    logic ep, er, erp;
    forever begin
      @(negedge clk);
      ep  = 1'b0;
      er  = 1'b0;
      erp = 1'b0;
      if (rst) begin
        exp_level = 1'b0;
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        if (sb[0].cyc == cyc) begin
          case (sb[0].kind)
            K_PRESS:   begin ep  = 1'b1; exp_level = 1'b1; end
            K_RELEASE: begin er  = 1'b1; exp_level = 1'b0; end
            K_REPEAT:  begin erp = 1'b1; end
            default:   begin end
          endcase
        end
        void'(sb.pop_front());
      end
      total++;
      if ({a_press, a_release, a_repeat, a_level} !== {ep, er, erp, exp_level}) begin
        bad++;
        $display("FAIL sb_rep_on cyc=%0d press/rel/rep/lvl got=%b want=%b",
                 cyc, {a_press, a_release, a_repeat, a_level}, {ep, er, erp, exp_level});
      end
      total++;
      if ({b_press, b_release, b_repeat, b_level} !== {ep, er, 1'b0, exp_level}) begin
        bad++;
        $display("FAIL sb_rep_off cyc=%0d press/rel/rep/lvl got=%b want=%b",
                 cyc, {b_press, b_release, b_repeat, b_level}, {ep, er, 1'b0, exp_level});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    raw_in = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({a_level, a_press, a_release, a_repeat, b_level, b_press, b_release, b_repeat} !== 8'h00) begin
      bad++;
      $display("FAIL reset_state got=%b want=00000000",
               {a_level, a_press, a_release, a_repeat, b_level, b_press, b_release, b_repeat});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_press();
    int c;
    c = cyc;
    raw_in = 1'b1;
    push_ev(c + LAT, K_PRESS);
    wait_cyc(c + 8);
    c = cyc;
    raw_in = 1'b0;
    push_ev(c + LAT, K_RELEASE);
    wait_cyc(c + 10);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL clean_press_pending got=%0d want=0", sb.size());
    end
  endtask

  task automatic test_glitch();
    int c;
    c = cyc;
    raw_in = 1'b1;
    wait_cyc(c + 3);
    raw_in = 1'b0;
    wait_cyc(c + 12);
    total++;
    if (a_level !== 1'b0 || b_level !== 1'b0) begin
      bad++;
      $display("FAIL glitch_level got=%b%b want=00", a_level, b_level);
    end
  endtask

  task automatic test_release_bounce();
    int c;
    c = cyc;
    raw_in = 1'b1;
    push_ev(c + LAT, K_PRESS);
    wait_cyc(c + LAT + 1);
    c = cyc;
    raw_in = 1'b0;
    wait_cyc(c + 2);
    raw_in = 1'b1;
    wait_cyc(c + 3);
    raw_in = 1'b0;
    push_ev(c + 3 + LAT, K_RELEASE);
    wait_cyc(c + 16);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL bounce_pending got=%0d want=0", sb.size());
    end
  endtask

  task automatic hold_and_release(input int hold_len);
    int c, t;
    c = cyc;
    raw_in = 1'b1;
    t = c + LAT;
    push_ev(t, K_PRESS);
    // FSM still sees s=1 for SYNC cycles after raw_in drops.
    for (int k = HOLD; k <= hold_len + SYNC; k += REP) push_ev(t + k, K_REPEAT);
    wait_cyc(t + hold_len);
    c = cyc;
    raw_in = 1'b0;
    push_ev(c + LAT, K_RELEASE);
    wait_cyc(c + LAT + 8);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL hold_%0d_pending got=%0d want=0", hold_len, sb.size());
    end
  endtask

  task automatic test_auto_repeat();
    hold_and_release(30);
  endtask

  task automatic test_reset_mid_hold();
    int c;
    c = cyc;
    raw_in = 1'b1;
    push_ev(c + LAT, K_PRESS);
    wait_cyc(c + LAT + 3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({a_level, a_press, a_release, a_repeat, b_level, b_press, b_release, b_repeat} !== 8'h00) begin
      bad++;
      $display("FAIL async_reset got=%b want=00000000",
               {a_level, a_press, a_release, a_repeat, b_level, b_press, b_release, b_repeat});
    end
    @(negedge clk);
    @(negedge clk);
    c = cyc;
    rst = 1'b0;
    push_ev(c + LAT, K_PRESS);
    wait_cyc(c + LAT + 1);
    c = cyc;
    raw_in = 1'b0;
    push_ev(c + LAT, K_RELEASE);
    wait_cyc(c + LAT + 6);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL reset_mid_hold_pending got=%0d want=0", sb.size());
    end
  endtask

  task automatic test_no_repeat();
    hold_and_release(100);
  endtask

  initial begin
    fork
      scoreboard_monitor();
    join_none
    test_reset();
    test_clean_press();
    test_glitch();
    test_release_bounce();
    test_auto_repeat();
    test_reset_mid_hold();
    test_no_repeat();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_debounce_one_pulse
